// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver. 2-flop synchroniser, 3-sample
// majority vote around mid-bit, optional parity and 1-2 stop bits, and a
// valid/ready holding register that flags overruns when a word is dropped.
module uart_rx_param #(
   parameter int CLK_FREQ  = 300000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx_serial,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_overrun,
   output logic                 o_rx_active
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int H            = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int BW           = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_S0      = CW'(H - 1);
   localparam logic [CW-1:0] C_S1      = CW'(H);
   localparam logic [CW-1:0] C_S2      = CW'(H + 1);
   localparam logic [BW-1:0] IDX_DLAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] IDX_SLAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [BW-1:0]        r_bit_idx, w_idx_nxt;
   logic [1:0]           r_sync;
   logic                 r_s0, r_s1;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_perr, r_ferr;
   logic                 r_valid, r_ferr_o, r_perr_o, r_overrun, r_active;
   logic                 w_rx_s, w_maj, w_at_mid, w_bit_end;
   logic                 w_done, w_frame_start, w_par_exp, w_ferr_fin;

   assign w_rx_s     = r_sync[1];
   // Third sample is the live synchronised line, so the vote resolves at cnt=H+1.
   assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
   assign w_at_mid   = (r_cnt == C_S2);
   assign w_bit_end  = (r_cnt == C_LAST);
   assign w_par_exp  = (PARITY == 2) ? ^r_shift : ~^r_shift;
   // The last stop bit is folded in combinationally since the frame ends on its vote.
   assign w_ferr_fin = r_ferr | ~w_maj;

   // State, bit timer and bit index registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_idx_nxt;
      end
   end

   // Next-state, timer and bit-index logic; frame start/complete strobes.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + 1'b1;
      w_idx_nxt     = r_bit_idx;
      w_done        = 1'b0;
      w_frame_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (!w_rx_s) begin
               w_state_nxt   = S_START;
               w_frame_start = 1'b1;
            end
         end
         S_START: begin
            if (w_at_mid && w_maj) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_bit_idx == IDX_DLAST) begin
                  w_idx_nxt = '0;
                  if (PARITY != 0) w_state_nxt = S_PAR;
                  else             w_state_nxt = S_STOP;
               end else begin
                  w_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
         S_PAR: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         end
         S_STOP: begin
            // Leave half a bit early so a back-to-back start edge is not missed.
            if (w_at_mid && r_bit_idx == IDX_SLAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_done      = 1'b1;
            end else if (w_bit_end) begin
               w_cnt_nxt = '0;
               w_idx_nxt = r_bit_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Synchroniser, vote samples, data shift and per-frame error accumulation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= 2'b11;
         r_s0    <= 1'b0;
         r_s1    <= 1'b0;
         r_shift <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_rx_serial};
         if (r_cnt == C_S0) r_s0 <= w_rx_s;
         if (r_cnt == C_S1) r_s1 <= w_rx_s;
         for (int k = 0; k < DATA_BITS; k++) begin
            if (r_state == S_DATA && w_at_mid && r_bit_idx == BW'(k)) r_shift[k] <= w_maj;
         end
         if (w_frame_start) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
         end
         if (r_state == S_PAR && w_at_mid) r_perr <= (w_maj != w_par_exp);
         if (r_state == S_STOP && w_at_mid && !w_maj) r_ferr <= 1'b1;
      end
   end

   // Output holding register: load on completion unless a word is still unaccepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr_o  <= 1'b0;
         r_perr_o  <= 1'b0;
         r_overrun <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         r_active  <= (w_state_nxt != S_IDLE);
         if (w_done) begin
            if (!r_valid || i_rx_ready) begin
               r_data   <= r_shift;
               r_valid  <= 1'b1;
               r_ferr_o <= w_ferr_fin;
               r_perr_o <= r_perr;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && i_rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_rx_data    = r_data;
   assign o_rx_valid   = r_valid;
   assign o_frame_err  = r_ferr_o;
   assign o_parity_err = (PARITY != 0) && r_perr_o;
   assign o_overrun    = r_overrun;
   assign o_rx_active  = r_active;

endmodule
